// File: rtl/cache_tag_array.sv
// cache_tag_array: set-associative tag store ({valid, dirty, tag} per way)
// with tree pseudo-LRU replacement, hit detection and victim selection.
// A hardware sweep clears every set after reset.
// Optional feature macro: TAG_DIRTY_EN (per-line dirty bits are stored).
module cache_tag_array #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 20,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [SET_BITS-1:0] req_set_i,
    input  logic [TAG_BITS-1:0] req_tag_i,
    output logic                rsp_valid_o,
    output logic                rsp_hit_o,
    output logic [WAY_BITS-1:0] rsp_way_o,
    output logic                rsp_victim_valid_o,
    output logic [TAG_BITS-1:0] rsp_victim_tag_o,
    output logic                rsp_victim_dirty_o,
    output logic                init_done_o
);
    localparam int SETS  = 2 ** SET_BITS;
    localparam int NODES = WAYS - 1;
`ifdef TAG_DIRTY_EN
    localparam int ENTRY_W = TAG_BITS + 2;
`else
    localparam int ENTRY_W = TAG_BITS + 1;
`endif

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_DIRTY  = 2'b11;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOOKUP} state_t;

    state_t                state_q, state_d;
    logic [SET_BITS-1:0]   init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [WAY_BITS-1:0]   rsp_way_q, rsp_way_d;
    logic                  rsp_vvalid_q, rsp_vvalid_d;
    logic [TAG_BITS-1:0]   rsp_vtag_q, rsp_vtag_d;
`ifdef TAG_DIRTY_EN
    logic                  rsp_vdirty_q, rsp_vdirty_d;
`endif

    logic [1:0]            op_q, op_d;
    logic [SET_BITS-1:0]   set_q, set_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;

    logic [ENTRY_W-1:0]    tag_mem [WAYS][SETS];
    logic [NODES-1:0]      plru_mem [SETS];
    logic [ENTRY_W-1:0]    rd_q [WAYS];
    logic [NODES-1:0]      plru_rd_q;

    logic                  accept;
    logic [WAYS-1:0]       rd_valid;
    logic [TAG_BITS-1:0]   rd_tag [WAYS];
`ifdef TAG_DIRTY_EN
    logic [WAYS-1:0]       rd_dirty;
    logic                  wr_dirty;
`endif
    logic                  any_hit, inv_found;
    logic [WAY_BITS-1:0]   hit_way, inv_way, victim_way;

    logic [WAYS-1:0]       way_we;
    logic [SET_BITS-1:0]   wr_set;
    logic                  wr_valid;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [ENTRY_W-1:0]    wr_entry;
    logic                  plru_we;
    logic [NODES-1:0]      plru_wdata;

    // Walk the tree from the root: a 0 node bit selects the lower-index half.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NODES-1:0] tree);
        logic [WAY_BITS-1:0] way;
        logic [NODES-1:0]    sh;
        int                  node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            sh = tree >> node;
            way[WAY_BITS-1-lvl] = sh[0];
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return way;
    endfunction

    // Point every node on the way's path away from that way.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                    input logic [WAY_BITS-1:0] way);
        logic [NODES-1:0] t;
        logic [NODES-1:0] mask;
        logic             b;
        int               node;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            b    = way[WAY_BITS-1-lvl];
            mask = NODES'(1) << node;
            t    = b ? (t & ~mask) : (t | mask);
            node = 2 * node + (b ? 2 : 1);
        end
        return t;
    endfunction

    assign req_ready_o        = (state_q == ST_IDLE);
    assign accept             = req_valid_i & req_ready_o;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_hit_o          = rsp_hit_q;
    assign rsp_way_o          = rsp_way_q;
    assign rsp_victim_valid_o = rsp_vvalid_q;
    assign rsp_victim_tag_o   = rsp_vtag_q;
    assign init_done_o        = init_done_q;
`ifdef TAG_DIRTY_EN
    assign rsp_victim_dirty_o = rsp_vdirty_q;
`else
    assign rsp_victim_dirty_o = 1'b0;
`endif

    // Decode read entries, find the lowest hit way and the replacement victim.
    always_comb begin
        any_hit   = 1'b0;
        inv_found = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            rd_valid[w] = rd_q[w][ENTRY_W-1];
            rd_tag[w]   = rd_q[w][TAG_BITS-1:0];
`ifdef TAG_DIRTY_EN
            rd_dirty[w] = rd_q[w][TAG_BITS];
`endif
            if (rd_valid[w] && (rd_tag[w] == tag_q)) begin
                any_hit = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!rd_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        victim_way = inv_found ? inv_way : plru_victim(plru_rd_q);
    end

    // Request fields are captured only when a request is accepted.
    always_comb begin
        op_d  = accept ? req_op_i  : op_q;
        set_d = accept ? req_set_i : set_q;
        tag_d = accept ? req_tag_i : tag_q;
    end

    // FSM next state, init sweep, write-back and response generation.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        rsp_valid_d  = 1'b0;
        rsp_hit_d    = rsp_hit_q;
        rsp_way_d    = rsp_way_q;
        rsp_vvalid_d = rsp_vvalid_q;
        rsp_vtag_d   = rsp_vtag_q;
`ifdef TAG_DIRTY_EN
        rsp_vdirty_d = rsp_vdirty_q;
        wr_dirty     = 1'b0;
`endif
        way_we       = '0;
        wr_set       = set_q;
        wr_valid     = 1'b0;
        wr_tag       = tag_q;
        plru_we      = 1'b0;
        plru_wdata   = plru_rd_q;
        case (state_q)
            ST_INIT: begin
                way_we     = '1;
                wr_set     = init_cnt_q;
                wr_tag     = '0;
                plru_we    = 1'b1;
                plru_wdata = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_hit_d    = any_hit;
                rsp_way_d    = any_hit ? hit_way : victim_way;
                rsp_vvalid_d = !any_hit && rd_valid[victim_way];
                rsp_vtag_d   = any_hit ? '0 : rd_tag[victim_way];
`ifdef TAG_DIRTY_EN
                rsp_vdirty_d = !any_hit && rd_dirty[victim_way];
`endif
                if (any_hit) begin
                    case (op_q)
                        OP_INVAL: begin
                            way_we[hit_way] = 1'b1;
                        end
                        OP_DIRTY: begin
`ifdef TAG_DIRTY_EN
                            way_we[hit_way] = 1'b1;
                            wr_valid        = 1'b1;
                            wr_dirty        = 1'b1;
`endif
                            plru_we    = 1'b1;
                            plru_wdata = plru_touch(plru_rd_q, hit_way);
                        end
                        default: begin
                            plru_we    = 1'b1;
                            plru_wdata = plru_touch(plru_rd_q, hit_way);
                        end
                    endcase
                end else if (op_q == OP_FILL) begin
                    way_we[victim_way] = 1'b1;
                    wr_valid           = 1'b1;
                    plru_we            = 1'b1;
                    plru_wdata         = plru_touch(plru_rd_q, victim_way);
                end
            end
            default: state_d = ST_INIT;
        endcase
`ifdef TAG_DIRTY_EN
        wr_entry = {wr_valid, wr_dirty, wr_tag};
`else
        wr_entry = {wr_valid, wr_tag};
`endif
    end

    // Control and response registers; reset drops any in-flight request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_vvalid_q <= 1'b0;
            rsp_vtag_q   <= '0;
`ifdef TAG_DIRTY_EN
            rsp_vdirty_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_vvalid_q <= rsp_vvalid_d;
            rsp_vtag_q   <= rsp_vtag_d;
`ifdef TAG_DIRTY_EN
            rsp_vdirty_q <= rsp_vdirty_d;
`endif
        end
    end

    // Latched request fields (datapath, no reset needed).
    always_ff @(posedge clk_i) begin
        op_q  <= op_d;
        set_q <= set_d;
        tag_q <= tag_d;
    end

    // Synchronous-read tag and PLRU RAMs: read on accept, write-back in LOOKUP.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (way_we[w]) tag_mem[w][wr_set] <= wr_entry;
            if (accept) rd_q[w] <= tag_mem[w][req_set_i];
        end
        if (plru_we) plru_mem[wr_set] <= plru_wdata;
        if (accept) plru_rd_q <= plru_mem[req_set_i];
    end
endmodule

// File: tb/tb_cache_tag_array.sv
// Self-checking bench for cache_tag_array (WAYS=4, SET_BITS=6, TAG_BITS=20).
module tb_cache_tag_array;
    localparam int WAYS = 4;
    localparam int SETS = 64;
    localparam int TB   = 20;
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_DIRTY  = 2'b11;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'b00;
    logic [5:0]    req_set_i = 6'd0;
    logic [TB-1:0] req_tag_i = '0;
    logic          rsp_valid_o, rsp_hit_o, rsp_victim_valid_o, rsp_victim_dirty_o, init_done_o;
    logic [1:0]    rsp_way_o;
    logic [TB-1:0] rsp_victim_tag_o;

    int checks = 0;
    int failures = 0;

    cache_tag_array #(.WAYS(4), .SET_BITS(6), .TAG_BITS(20)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_set_i(req_set_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o),
        .rsp_victim_valid_o(rsp_victim_valid_o), .rsp_victim_tag_o(rsp_victim_tag_o),
        .rsp_victim_dirty_o(rsp_victim_dirty_o), .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    // Reference model: per-line state plus the three PLRU tree bits of each set.
    bit            m_valid [SETS][WAYS];
    bit            m_dirty [SETS][WAYS];
    logic [TB-1:0] m_tag   [SETS][WAYS];
    bit            m_root [SETS];
    bit            m_left [SETS];
    bit            m_right[SETS];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_root[s] = 0; m_left[s] = 0; m_right[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
            end
        end
    endfunction

    // Ways 0/1 live under the left node, 2/3 under the right; bits point away.
    function automatic void model_touch(input int s, input int w);
        if (w < 2) begin m_root[s] = 1; m_left[s] = (w == 0); end
        else begin m_root[s] = 0; m_right[s] = (w == 2); end
    endfunction

    function automatic int model_plru_victim(input int s);
        if (m_root[s]) return m_right[s] ? 3 : 2;
        return m_left[s] ? 1 : 0;
    endfunction

    task automatic model_apply(input logic [1:0] op, input int s, input logic [TB-1:0] tag,
                               output bit hit, output int way, output bit vv,
                               output logic [TB-1:0] vt, output bit vd);
        hit = 0; way = 0; vv = 0; vt = '0; vd = 0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == tag) begin hit = 1; way = w; end
        if (hit) begin
            if (op == OP_INVAL) begin
                m_valid[s][way] = 0; m_dirty[s][way] = 0;
            end else begin
`ifdef TAG_DIRTY_EN
                if (op == OP_DIRTY) m_dirty[s][way] = 1;
`endif
                model_touch(s, way);
            end
        end else begin
            way = -1;
            for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) way = model_plru_victim(s);
            vv = m_valid[s][way]; vt = m_tag[s][way]; vd = m_dirty[s][way];
            if (op == OP_FILL) begin
                m_valid[s][way] = 1; m_dirty[s][way] = 0; m_tag[s][way] = tag;
                model_touch(s, way);
            end
        end
    endtask

    // Issue one request from a negedge; return the response sampled at the
    // negedge after the response edge. Fields are scrambled once accepted.
    task automatic do_req(input logic [1:0] op, input int s, input logic [TB-1:0] tag,
                          output logic v, output logic h, output logic [1:0] w,
                          output logic vv, output logic [TB-1:0] vt, output logic vd);
        int guard = 0;
        while (!req_ready_o && guard < 500) begin @(negedge clk); guard++; end
        checks++;
        if (!req_ready_o) begin
            failures++;
            $display("FAIL req_ready_timeout: ready=%0b required=1", req_ready_o);
        end
        req_valid_i = 1'b1; req_op_i = op; req_set_i = 6'(s); req_tag_i = tag;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_op_i = 2'($urandom); req_set_i = 6'($urandom); req_tag_i = 20'($urandom);
        @(posedge clk);
        @(negedge clk);
        v = rsp_valid_o; h = rsp_hit_o; w = rsp_way_o;
        vv = rsp_victim_valid_o; vt = rsp_victim_tag_o; vd = rsp_victim_dirty_o;
    endtask

    task automatic test_reset();
        int cyc = 0;
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        #2 rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b required 0", req_ready_o); end
        if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid_o); end
        if (rsp_hit_o !== 1'b0) begin failures++; $display("FAIL reset_hit: got %0b required 0", rsp_hit_o); end
        if (rsp_way_o !== 2'd0) begin failures++; $display("FAIL reset_way: got %0d required 0", rsp_way_o); end
        if (rsp_victim_valid_o !== 1'b0 || rsp_victim_dirty_o !== 1'b0) begin failures++; $display("FAIL reset_victim_flags: got %0b%0b required 00", rsp_victim_valid_o, rsp_victim_dirty_o); end
        if (rsp_victim_tag_o !== '0) begin failures++; $display("FAIL reset_victim_tag: got %0h required 0", rsp_victim_tag_o); end
        if (init_done_o !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %0b required 0", init_done_o); end
        rst_i = 1'b0;
        model_reset();
        while (!req_ready_o && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks += 2;
        if (cyc != 64) begin failures++; $display("FAIL init_cycles: got %0d required 64", cyc); end
        if (init_done_o !== 1'b1) begin failures++; $display("FAIL init_done: got %0b required 1", init_done_o); end
        @(negedge clk);
        do_req(OP_LOOKUP, 0, '0, v, h, w, vv, vt, vd);
        model_apply(OP_LOOKUP, 0, '0, eh, ew, evv, evt, evd);
        checks += 4;
        if (v !== 1'b1) begin failures++; $display("FAIL first_rsp_valid: got %0b required 1", v); end
        if (h !== 1'b0) begin failures++; $display("FAIL first_lookup_hit: got %0b required 0", h); end
        if (w !== 2'(ew)) begin failures++; $display("FAIL first_lookup_way: got %0d required %0d", w, ew); end
        if (vv !== evv || vt !== evt || vd !== evd) begin failures++; $display("FAIL first_lookup_victim: got %0b/%0h/%0b required %0b/%0h/%0b", vv, vt, vd, evv, evt, evd); end
    endtask

    task automatic test_fill();
        logic [TB-1:0] tags [4];
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        tags[0] = 20'hA; tags[1] = 20'hB; tags[2] = 20'hC; tags[3] = 20'hD;
        for (int i = 0; i < 4; i++) begin
            do_req(OP_FILL, 5, tags[i], v, h, w, vv, vt, vd);
            model_apply(OP_FILL, 5, tags[i], eh, ew, evv, evt, evd);
            checks += 3;
            if (v !== 1'b1 || h !== 1'b0) begin failures++; $display("FAIL fill_%0d_valid_hit: got %0b%0b required 10", i, v, h); end
            if (w !== 2'(i)) begin failures++; $display("FAIL fill_%0d_way: got %0d required %0d", i, w, i); end
            if (vv !== 1'b0) begin failures++; $display("FAIL fill_%0d_victim_valid: got %0b required 0", i, vv); end
        end
        do_req(OP_LOOKUP, 5, 20'hB, v, h, w, vv, vt, vd);
        model_apply(OP_LOOKUP, 5, 20'hB, eh, ew, evv, evt, evd);
        checks += 2;
        if (h !== 1'b1 || w !== 2'd1) begin failures++; $display("FAIL lookup_B: got hit=%0b way=%0d required hit=1 way=1", h, w); end
        if (vv !== 1'b0 || vt !== '0 || vd !== 1'b0) begin failures++; $display("FAIL lookup_B_victim_zero: got %0b/%0h/%0b required 0/0/0", vv, vt, vd); end
        do_req(OP_FILL, 5, 20'hE, v, h, w, vv, vt, vd);
        model_apply(OP_FILL, 5, 20'hE, eh, ew, evv, evt, evd);
        checks += 3;
        if (h !== 1'b0 || w !== 2'd2) begin failures++; $display("FAIL fill_E_way: got hit=%0b way=%0d required hit=0 way=2", h, w); end
        if (vv !== 1'b1 || vt !== 20'hC) begin failures++; $display("FAIL fill_E_victim: got valid=%0b tag=%0h required valid=1 tag=c", vv, vt); end
        if (vd !== evd) begin failures++; $display("FAIL fill_E_victim_dirty: got %0b required %0b", vd, evd); end
    endtask

    task automatic test_invalidate();
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        do_req(OP_INVAL, 5, 20'hB, v, h, w, vv, vt, vd);
        model_apply(OP_INVAL, 5, 20'hB, eh, ew, evv, evt, evd);
        checks++;
        if (h !== 1'b1 || w !== 2'd1) begin failures++; $display("FAIL inval_B: got hit=%0b way=%0d required hit=1 way=1", h, w); end
        do_req(OP_LOOKUP, 5, 20'hB, v, h, w, vv, vt, vd);
        model_apply(OP_LOOKUP, 5, 20'hB, eh, ew, evv, evt, evd);
        checks++;
        if (h !== 1'b0) begin failures++; $display("FAIL lookup_after_inval: got hit=%0b required 0", h); end
        do_req(OP_FILL, 5, 20'h1F, v, h, w, vv, vt, vd);
        model_apply(OP_FILL, 5, 20'h1F, eh, ew, evv, evt, evd);
        checks += 2;
        if (h !== 1'b0 || w !== 2'd1) begin failures++; $display("FAIL fill_into_invalid: got hit=%0b way=%0d required hit=0 way=1", h, w); end
        if (vv !== 1'b0) begin failures++; $display("FAIL fill_into_invalid_vv: got %0b required 0", vv); end
    endtask

    task automatic test_dirty();
        logic [1:0] ops [9];
        logic [TB-1:0] tags [9];
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        bit exp_dirty;
`ifdef TAG_DIRTY_EN
        exp_dirty = 1'b1;
`else
        exp_dirty = 1'b0;
`endif
        ops = '{OP_FILL, OP_FILL, OP_FILL, OP_FILL, OP_DIRTY, OP_LOOKUP, OP_LOOKUP, OP_LOOKUP, OP_FILL};
        tags = '{20'h1, 20'h2, 20'h3, 20'h4, 20'h1, 20'h2, 20'h3, 20'h4, 20'h5};
        for (int i = 0; i < 9; i++) begin
            do_req(ops[i], 9, tags[i], v, h, w, vv, vt, vd);
            model_apply(ops[i], 9, tags[i], eh, ew, evv, evt, evd);
            checks++;
            if (h !== eh || w !== 2'(ew)) begin failures++; $display("FAIL dirty_seq_%0d: got hit=%0b way=%0d required hit=%0b way=%0d", i, h, w, eh, ew); end
        end
        checks += 2;
        if (w !== 2'd0 || vt !== 20'h1 || vv !== 1'b1) begin failures++; $display("FAIL dirty_victim: got way=%0d tag=%0h valid=%0b required way=0 tag=1 valid=1", w, vt, vv); end
        if (vd !== exp_dirty) begin failures++; $display("FAIL dirty_victim_dirty: got %0b required %0b", vd, exp_dirty); end
    endtask

    task automatic test_back_to_back();
        int acc_cnt = 0;
        int pulse_cnt = 0;
        bit prev_acc = 0;
        bit acc, rdy;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        for (int i = 0; i < 9; i++) begin
            req_valid_i = (i < 6);
            req_op_i = OP_LOOKUP; req_set_i = 6'd20; req_tag_i = 20'h300 + 20'(i);
            rdy = req_ready_o;
            @(posedge clk);
            acc = req_valid_i && rdy;
            if (acc) begin
                acc_cnt++;
                model_apply(OP_LOOKUP, 20, req_tag_i, eh, ew, evv, evt, evd);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== prev_acc) begin failures++; $display("FAIL b2b_rsp_valid_cycle_%0d: got %0b required %0b", i, rsp_valid_o, prev_acc); end
            if (rsp_valid_o === 1'b1) pulse_cnt++;
            prev_acc = acc;
        end
        checks += 2;
        if (acc_cnt != 3) begin failures++; $display("FAIL b2b_accepts: got %0d required 3", acc_cnt); end
        if (pulse_cnt != 3) begin failures++; $display("FAIL b2b_pulses: got %0d required 3", pulse_cnt); end
    endtask

    task automatic test_random();
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        logic [1:0] op; int s; logic [TB-1:0] tag;
        for (int i = 0; i < 250; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) op = OP_FILL;
            s = 40 + $urandom_range(0, 3);
            tag = 20'($urandom_range(1, 6));
            do_req(op, s, tag, v, h, w, vv, vt, vd);
            model_apply(op, s, tag, eh, ew, evv, evt, evd);
            checks++;
            if (v !== 1'b1 || h !== eh || w !== 2'(ew) || vv !== evv || vt !== evt || vd !== evd)
            begin
                failures++;
                $display("FAIL random_%0d op=%0d set=%0d tag=%0h: got v=%0b h=%0b w=%0d vv=%0b vt=%0h vd=%0b required v=1 h=%0b w=%0d vv=%0b vt=%0h vd=%0b",
                         i, op, s, tag, v, h, w, vv, vt, vd, eh, ew, evv, evt, evd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int seen = 0;
        logic v, h, vv, vd; logic [1:0] w; logic [TB-1:0] vt;
        bit eh, evv, evd; int ew; logic [TB-1:0] evt;
        req_valid_i = 1'b1; req_op_i = OP_LOOKUP; req_set_i = 6'd5; req_tag_i = 20'hA;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) seen++;
        end
        checks += 2;
        if (seen != 0) begin failures++; $display("FAIL midreset_rsp: got %0d pulses required 0", seen); end
        if (req_ready_o !== 1'b0 || init_done_o !== 1'b0) begin failures++; $display("FAIL midreset_ready_done: got %0b%0b required 00", req_ready_o, init_done_o); end
        rst_i = 1'b0;
        model_reset();
        while (!req_ready_o && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (rsp_valid_o !== 1'b0) seen++;
        end
        checks += 2;
        if (cyc != 64) begin failures++; $display("FAIL reinit_cycles: got %0d required 64", cyc); end
        if (seen != 0) begin failures++; $display("FAIL reinit_rsp: got %0d pulses required 0", seen); end
        @(negedge clk);
        do_req(OP_LOOKUP, 5, 20'hA, v, h, w, vv, vt, vd);
        model_apply(OP_LOOKUP, 5, 20'hA, eh, ew, evv, evt, evd);
        checks += 2;
        if (v !== 1'b1 || h !== 1'b0) begin failures++; $display("FAIL post_reinit_lookup: got v=%0b hit=%0b required v=1 hit=0", v, h); end
        if (w !== 2'(ew) || vv !== evv) begin failures++; $display("FAIL post_reinit_victim: got way=%0d vv=%0b required way=%0d vv=%0b", w, vv, ew, evv); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_invalidate();
        test_dirty();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
